// File: rtl/rq_to_r3_reduce.sv
// Rq -> R3 reduction stage: streams P coefficients, centres mod Q, reduces mod 3, tracks degp/zerocount.
// Optional weight counter and weight_ok flag enabled by defining R3_WEIGHT_CNT_EN.
module rq_to_r3_reduce #(
   parameter int P  = 757,
   parameter int Q  = 5167,
   parameter int W  = 286,
   parameter int AW = 11,
   parameter int QW = 13
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          rq_rd_en,
   output logic [AW-1:0] rq_addr,
   input  logic [QW-1:0] rq_data,
   output logic          r3_we,
   output logic [AW-1:0] r3_addr,
   output logic [1:0]    r3_data,
   output logic [AW-1:0] degp,
   output logic [AW-1:0] zerocount,
   output logic          weight_ok,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   localparam logic [QW-1:0] Q_L      = QW'(Q);
   localparam logic [QW-1:0] HALF_L   = QW'((Q - 1) / 2);
   localparam logic [AW-1:0] LAST_L   = AW'(P - 1);
   localparam logic [2:0]    WRAP_ADJ = 3'((3 - (Q % 3)) % 3);

   state_t          state;
   logic            drain_cnt;
   logic            s1_valid;
   logic [AW-1:0]   s1_idx;

   logic [QW-1:0]   c_red;
   logic            wrap;
   logic [1:0]      m0;
   logic [2:0]      msum;
   logic [1:0]      r_code;

   // Residue of v = c' - Q (when wrapped) is (c' mod 3) - (Q mod 3), so no signed subtract is needed.
   always_comb begin
      c_red  = (rq_data >= Q_L) ? rq_data - Q_L : rq_data;
      wrap   = (c_red > HALF_L);
      m0     = 2'(c_red % QW'(3));
      msum   = {1'b0, m0} + (wrap ? WRAP_ADJ : 3'd0);
      if (msum >= 3'd3) msum = msum - 3'd3;
      r_code = 2'b00;
      case (msum)
         3'd1:    r_code = 2'b01;
         3'd2:    r_code = 2'b11;
         default: r_code = 2'b00;
      endcase
   end

`ifdef R3_WEIGHT_CNT_EN
   logic [AW-1:0] weight;
   logic [AW-1:0] weight_nxt;
   assign weight_nxt = (r_code != 2'b00) ? weight + AW'(1) : weight;
`else
   assign weight_ok = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         drain_cnt <= 1'b0;
         s1_valid  <= 1'b0;
         s1_idx    <= '0;
         rq_rd_en  <= 1'b0;
         rq_addr   <= '0;
         r3_we     <= 1'b0;
         r3_addr   <= '0;
         r3_data   <= 2'b00;
         degp      <= '0;
         zerocount <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef R3_WEIGHT_CNT_EN
         weight    <= '0;
         weight_ok <= 1'b0;
`endif
      end else begin
         done     <= 1'b0;
         r3_we    <= 1'b0;
         // S1: rq_data for the address issued last cycle is on the bus now
         s1_valid <= rq_rd_en;
         s1_idx   <= rq_addr;

         // S2: write the reduced coefficient and update the counters
         if (s1_valid) begin
            r3_we   <= 1'b1;
            r3_addr <= s1_idx;
            r3_data <= r_code;
            if (r_code == 2'b00) zerocount <= zerocount + AW'(1);
            else                 degp      <= s1_idx;
`ifdef R3_WEIGHT_CNT_EN
            weight    <= weight_nxt;
            weight_ok <= (weight_nxt == AW'(W));
`endif
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state     <= READ;
                  busy      <= 1'b1;
                  rq_rd_en  <= 1'b1;
                  rq_addr   <= '0;
                  degp      <= '0;
                  zerocount <= '0;
`ifdef R3_WEIGHT_CNT_EN
                  weight    <= '0;
                  weight_ok <= 1'b0;
`endif
               end
            end
            READ: begin
               if (rq_addr == LAST_L) begin
                  rq_rd_en  <= 1'b0;
                  drain_cnt <= 1'b0;
                  state     <= DRAIN;
               end else begin
                  rq_addr <= rq_addr + AW'(1);
               end
            end
            DRAIN: begin
               drain_cnt <= 1'b1;
               if (drain_cnt) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rq_to_r3_reduce.sv
// Directed bench for rq_to_r3_reduce: RAM model, write scoreboard, per-pass result checks.
module tb_rq_to_r3_reduce;

   localparam int P  = 757;
   localparam int AW = 11;
   localparam int QW = 13;
`ifdef R3_WEIGHT_CNT_EN
   localparam bit WEN = 1'b1;
`else
   localparam bit WEN = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          rq_rd_en;
   logic [AW-1:0] rq_addr;
   logic [QW-1:0] rq_data;
   logic          r3_we;
   logic [AW-1:0] r3_addr;
   logic [1:0]    r3_data;
   logic [AW-1:0] degp;
   logic [AW-1:0] zerocount;
   logic          weight_ok;
   logic          busy;
   logic          done;

   logic [QW-1:0]   mem   [0:P-1];
   logic [1:0]      exp_r [0:P-1];
   logic [AW+1:0]   exp_q [$];
   int              n_checks;
   int              n_errors;
   int              done_cnt;
   int              busy_cnt;

   rq_to_r3_reduce dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .rq_rd_en(rq_rd_en), .rq_addr(rq_addr), .rq_data(rq_data),
      .r3_we(r3_we), .r3_addr(r3_addr), .r3_data(r3_data),
      .degp(degp), .zerocount(zerocount), .weight_ok(weight_ok),
      .busy(busy), .done(done)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous-read coefficient RAM
   always @(posedge clk) if (rq_rd_en) rq_data <= mem[rq_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // scoreboard: every write must match the next expected {addr, data}
   always @(negedge clk) begin
      logic [AW+1:0] e;
      if (rst_n) begin
         if (done) done_cnt++;
         if (busy) busy_cnt++;
         if (r3_we) begin
            if (exp_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               check("r3_addr", 32'(r3_addr), 32'(e[AW+1:2]));
               check("r3_data", 32'(r3_data), 32'(e[1:0]));
            end
         end
      end
   end

   task automatic fill(input logic [QW-1:0] c, input logic [1:0] r);
      for (int i = 0; i < P; i++) begin
         mem[i]   = c;
         exp_r[i] = r;
      end
   endtask

   task automatic set_c(input int idx, input logic [QW-1:0] c, input logic [1:0] r);
      mem[idx]   = c;
      exp_r[idx] = r;
   endtask

   task automatic load_exp();
      exp_q.delete();
      for (int i = 0; i < P; i++) exp_q.push_back({AW'(i), exp_r[i]});
   endtask

   task automatic run_pass(input string name, input int e_degp, input int e_zc,
                           input bit e_wok, input bit poke);
      int cycles;
      load_exp();
      @(negedge clk);
      done_cnt = 0;
      busy_cnt = 0;
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      cycles = 1;
      while (!done && cycles < 2000) begin
         @(negedge clk);
         cycles++;
         if (poke && cycles == 50) start = 1'b1;
         else if (poke && cycles == 51) start = 1'b0;
      end
      check({name, "_latency"}, 32'(cycles), 32'd760);
      check({name, "_degp"}, 32'(degp), 32'(e_degp));
      check({name, "_zerocount"}, 32'(zerocount), 32'(e_zc));
      check({name, "_weight_ok"}, 32'(weight_ok), 32'(e_wok));
      if (poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, "_done_pulse"}, 32'(done), 32'd0);
      repeat (10) @(negedge clk);
      check({name, "_idle_busy"}, 32'(busy), 32'd0);
      check({name, "_done_count"}, 32'(done_cnt), 32'd1);
      check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd760);
      check({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
      check({name, "_degp_hold"}, 32'(degp), 32'(e_degp));
      check({name, "_zc_hold"}, 32'(zerocount), 32'(e_zc));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      done_cnt = 0;
      busy_cnt = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      fill(13'd0, 2'b00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_rd_en", 32'(rq_rd_en), 32'd0);
      check("rst_rq_addr", 32'(rq_addr), 32'd0);
      check("rst_we", 32'(r3_we), 32'd0);
      check("rst_r3_addr", 32'(r3_addr), 32'd0);
      check("rst_r3_data", 32'(r3_data), 32'd0);
      check("rst_degp", 32'(degp), 32'd0);
      check("rst_zerocount", 32'(zerocount), 32'd0);
      check("rst_weight_ok", 32'(weight_ok), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);

      fill(13'd0, 2'b00);
      run_pass("zeros", 0, 757, 1'b0, 1'b0);

      fill(13'd1, 2'b01);
      run_pass("ones", 756, 0, 1'b0, 1'b0);

      // centring and out-of-range edges
      fill(13'd0, 2'b00);
      set_c(10, 13'd2583, 2'b00);
      set_c(11, 13'd2584, 2'b00);
      set_c(12, 13'd5166, 2'b11);
      set_c(13, 13'd5168, 2'b01);
      set_c(500, 13'd3, 2'b00);
      set_c(600, 13'd2, 2'b11);
      set_c(650, 13'd8191, 2'b11);
      set_c(700, 13'd4000, 2'b00);
      run_pass("edges", 650, 753, 1'b0, 1'b0);

      fill(13'd0, 2'b00);
      for (int i = 0; i < 286; i++) set_c(i, 13'd1, 2'b01);
      run_pass("weight", 285, 471, WEN, 1'b0);

      // abort mid-pass with reset, then a clean full pass
      fill(13'd1, 2'b01);
      load_exp();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (99) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_we", 32'(r3_we), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_rd_en", 32'(rq_rd_en), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      repeat (5) @(negedge clk);
      check("abort_no_write", 32'(r3_we), 32'd0);
      run_pass("after_abort", 756, 0, 1'b0, 1'b0);

      // start while busy and in the done cycle are both ignored
      fill(13'd0, 2'b00);
      set_c(300, 13'd5, 2'b11);
      run_pass("poke", 300, 756, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
